// File: rtl/otter_io_ctrl.sv
// otter_io_ctrl: memory-mapped I/O slave for the OTTER IOBUS.
// Provides switch/button synchronisation and debounce, button-edge interrupt
// latching with mask and write-1-to-clear, a self-scanning 4-digit hex
// seven-segment driver, and readback of all registers.
// Optional build macro OTTER_IO_BOTH_EDGE_EN adds IRQ_EDGE at OUT_BASE+0x14.
module otter_io_ctrl #(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned BTN_W     = 5,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] IN_BASE   = 32'h11008000,
  parameter logic [31:0] OUT_BASE  = 32'h1100C000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      IOBUS_addr,
  input  logic [31:0]      IOBUS_out,
  input  logic             IOBUS_wr,
  output logic [31:0]      IOBUS_in,
  input  logic [SW_W-1:0]  switches,
  input  logic [BTN_W-1:0] buttons,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       segs,
  output logic [3:0]       an,
  output logic             intr
);

  localparam int unsigned DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [31:0] A_IN_SW    = IN_BASE  + 32'h0;
  localparam logic [31:0] A_IN_BTN   = IN_BASE  + 32'h4;
  localparam logic [31:0] A_IN_PEND  = IN_BASE  + 32'h8;
  localparam logic [31:0] A_LEDS     = OUT_BASE + 32'h00;
  localparam logic [31:0] A_SDATA    = OUT_BASE + 32'h04;
  localparam logic [31:0] A_SEN      = OUT_BASE + 32'h08;
  localparam logic [31:0] A_IRQ_CLR  = OUT_BASE + 32'h0C;
  localparam logic [31:0] A_IRQ_EN   = OUT_BASE + 32'h10;
  localparam logic [31:0] A_IRQ_EDGE = OUT_BASE + 32'h14;

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [BTN_W-1:0] db_q, db_d, db_prev_q;
  logic [DB_W-1:0]  db_cnt_q [BTN_W];
  logic [DB_W-1:0]  db_cnt_d [BTN_W];
  logic [BTN_W-1:0] pend_q, pend_d, edge_set, clr_mask;
  logic [BTN_W-1:0] irq_en_q, irq_edge_q;
  logic [LED_W-1:0] leds_q;
  logic [15:0]      sdata_q;
  logic [3:0]       sen_q;
  logic             intr_q;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [7:0]       segs_q, segs_d;
  logic [3:0]       an_q, an_d;
  logic             scan_wrap;
  logic             we_leds, we_sdata, we_sen, we_clr, we_en, we_edge;
  logic             unused_bus;

  assign unused_bus = ^IOBUS_out;

  // Active-low seven-segment decode, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Write strobes for the output register block.
  always_comb begin
    we_leds  = IOBUS_wr && (IOBUS_addr == A_LEDS);
    we_sdata = IOBUS_wr && (IOBUS_addr == A_SDATA);
    we_sen   = IOBUS_wr && (IOBUS_addr == A_SEN);
    we_clr   = IOBUS_wr && (IOBUS_addr == A_IRQ_CLR);
    we_en    = IOBUS_wr && (IOBUS_addr == A_IRQ_EN);
`ifdef OTTER_IO_BOTH_EDGE_EN
    we_edge  = IOBUS_wr && (IOBUS_addr == A_IRQ_EDGE);
`else
    we_edge  = 1'b0;
`endif
  end

  // Per-button debounce: flip after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < BTN_W; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) db_d[i] = btn_s2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Pending latch: edge set wins over a same-cycle W1C clear.
  always_comb begin
    edge_set = db_q & ~db_prev_q;
`ifdef OTTER_IO_BOTH_EDGE_EN
    edge_set = edge_set | (~db_q & db_prev_q & irq_edge_q);
`endif
    clr_mask = we_clr ? IOBUS_out[BTN_W-1:0] : '0;
    pend_d   = (pend_q & ~clr_mask) | edge_set;
  end

  // Input synchronisers, debounce state, pending bits and interrupt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < BTN_W; i++) db_cnt_q[i] <= '0;
      pend_q    <= '0;
      intr_q    <= 1'b0;
    end else begin
      sw_s1_q   <= switches;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= buttons;
      btn_s2_q  <= btn_s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < BTN_W; i++) db_cnt_q[i] <= db_cnt_d[i];
      pend_q    <= pend_d;
      intr_q    <= |(pend_q & irq_en_q);
    end
  end

  // Bus-writable configuration registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds_q     <= '0;
      sdata_q    <= '0;
      sen_q      <= '0;
      irq_en_q   <= '0;
      irq_edge_q <= '0;
    end else begin
      if (we_leds)  leds_q     <= IOBUS_out[LED_W-1:0];
      if (we_sdata) sdata_q    <= IOBUS_out[15:0];
      if (we_sen)   sen_q      <= IOBUS_out[3:0];
      if (we_en)    irq_en_q   <= IOBUS_out[BTN_W-1:0];
      if (we_edge)  irq_edge_q <= IOBUS_out[BTN_W-1:0];
    end
  end

  // Digit scan: slot counter, digit index and next segment/anode pattern.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    dig_d      = scan_wrap ? dig_q + 2'd1 : dig_q;
    segs_d     = 8'hFF;
    an_d       = 4'hF;
    if (sen_q[dig_q]) begin
      an_d   = ~(4'b0001 << dig_q);
      segs_d = {1'b1, hex7(sdata_q[{dig_q, 2'b00} +: 4])};
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
      segs_q     <= 8'hFF;
      an_q       <= 4'hF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      segs_q     <= segs_d;
      an_q       <= an_d;
    end
  end

  // Combinational readback; unmapped addresses read zero.
  always_comb begin
    IOBUS_in = '0;
    case (IOBUS_addr)
      A_IN_SW:   IOBUS_in = 32'(sw_s2_q);
      A_IN_BTN:  IOBUS_in = 32'(db_q);
      A_IN_PEND: IOBUS_in = 32'(pend_q);
      A_LEDS:    IOBUS_in = 32'(leds_q);
      A_SDATA:   IOBUS_in = 32'(sdata_q);
      A_SEN:     IOBUS_in = 32'(sen_q);
      A_IRQ_EN:  IOBUS_in = 32'(irq_en_q);
`ifdef OTTER_IO_BOTH_EDGE_EN
      A_IRQ_EDGE: IOBUS_in = 32'(irq_edge_q);
`endif
      default:   IOBUS_in = '0;
    endcase
  end

  assign leds = leds_q;
  assign segs = segs_q;
  assign an   = an_q;
  assign intr = intr_q;

endmodule

// File: tb/tb_otter_io_ctrl.sv
// Testbench for otter_io_ctrl: directed scenarios plus randomized bus and
// button traffic, checked every cycle against a behavioural model.
module tb_otter_io_ctrl;

  localparam int unsigned SW_W      = 16;
  localparam int unsigned BTN_W     = 5;
  localparam int unsigned LED_W     = 16;
  localparam int unsigned DB_CYCLES = 8;
  localparam int unsigned SCAN_DIV  = 4;
  localparam logic [31:0] IN_BASE   = 32'h11008000;
  localparam logic [31:0] OUT_BASE  = 32'h1100C000;

  logic             CLK, RST_N;
  logic [31:0]      IOBUS_addr, IOBUS_out, IOBUS_in;
  logic             IOBUS_wr;
  logic [SW_W-1:0]  switches;
  logic [BTN_W-1:0] buttons;
  logic [LED_W-1:0] leds;
  logic [7:0]       segs;
  logic [3:0]       an;
  logic             intr;

  otter_io_ctrl #(
    .SW_W(SW_W), .BTN_W(BTN_W), .LED_W(LED_W), .DB_CYCLES(DB_CYCLES),
    .SCAN_DIV(SCAN_DIV), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IOBUS_addr(IOBUS_addr), .IOBUS_out(IOBUS_out),
    .IOBUS_wr(IOBUS_wr), .IOBUS_in(IOBUS_in), .switches(switches),
    .buttons(buttons), .leds(leds), .segs(segs), .an(an), .intr(intr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]       lit [16];   // lit segments per hex digit, active-high {g..a}
  logic [SW_W-1:0]  m_sw_s1, m_sw;
  logic [BTN_W-1:0] m_btn_s1, m_btn, m_db, m_db_d1, m_pend, m_en, m_edge;
  logic [DB_CYCLES-1:0] m_hist [BTN_W];
  logic [LED_W-1:0] m_leds;
  logic [15:0]      m_sdata;
  logic [3:0]       m_sen, m_an;
  logic [7:0]       m_segs;
  logic             m_intr;
  int               m_cyc;

  initial begin
    lit[0] = 7'h3F; lit[1] = 7'h06; lit[2] = 7'h5B; lit[3] = 7'h4F;
    lit[4] = 7'h66; lit[5] = 7'h6D; lit[6] = 7'h7D; lit[7] = 7'h07;
    lit[8] = 7'h7F; lit[9] = 7'h6F; lit[10] = 7'h77; lit[11] = 7'h7C;
    lit[12] = 7'h39; lit[13] = 7'h5E; lit[14] = 7'h79; lit[15] = 7'h71;
  end

  task automatic m_reset();
    m_sw_s1 = '0; m_sw = '0; m_btn_s1 = '0; m_btn = '0;
    m_db = '0; m_db_d1 = '0; m_pend = '0; m_en = '0; m_edge = '0;
    for (int i = 0; i < BTN_W; i++) m_hist[i] = '0;
    m_leds = '0; m_sdata = '0; m_sen = '0; m_an = 4'hF; m_segs = 8'hFF;
    m_intr = 1'b0; m_cyc = 0;
  endtask

  task automatic m_step();
    logic [BTN_W-1:0] set, clr, n_db;
    int dig;
    set = m_db & ~m_db_d1;
`ifdef OTTER_IO_BOTH_EDGE_EN
    set = set | (~m_db & m_db_d1 & m_edge);
`endif
    clr = (IOBUS_wr && IOBUS_addr == OUT_BASE + 32'hC) ? IOBUS_out[BTN_W-1:0] : '0;
    m_intr = |(m_pend & m_en);
    m_pend = (m_pend & ~clr) | set;
    dig = (m_cyc / SCAN_DIV) % 4;
    m_an = 4'hF;
    m_segs = 8'hFF;
    if (m_sen[dig]) begin
      m_an[dig] = 1'b0;
      m_segs = {1'b1, ~lit[m_sdata[dig*4 +: 4]]};
    end
    n_db = m_db;
    for (int i = 0; i < BTN_W; i++) begin
      m_hist[i] = {m_hist[i][DB_CYCLES-2:0], m_btn[i]};
      if (m_hist[i] == {DB_CYCLES{~m_db[i]}}) n_db[i] = ~m_db[i];
    end
    m_db_d1 = m_db;
    m_db = n_db;
    m_btn = m_btn_s1;  m_btn_s1 = buttons;
    m_sw = m_sw_s1;    m_sw_s1 = switches;
    if (IOBUS_wr) begin
      if (IOBUS_addr == OUT_BASE + 32'h00) m_leds  = IOBUS_out[LED_W-1:0];
      if (IOBUS_addr == OUT_BASE + 32'h04) m_sdata = IOBUS_out[15:0];
      if (IOBUS_addr == OUT_BASE + 32'h08) m_sen   = IOBUS_out[3:0];
      if (IOBUS_addr == OUT_BASE + 32'h10) m_en    = IOBUS_out[BTN_W-1:0];
`ifdef OTTER_IO_BOTH_EDGE_EN
      if (IOBUS_addr == OUT_BASE + 32'h14) m_edge  = IOBUS_out[BTN_W-1:0];
`endif
    end
    m_cyc++;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == IN_BASE + 32'h0)   return 32'(m_sw);
    if (a == IN_BASE + 32'h4)   return 32'(m_db);
    if (a == IN_BASE + 32'h8)   return 32'(m_pend);
    if (a == OUT_BASE + 32'h00) return 32'(m_leds);
    if (a == OUT_BASE + 32'h04) return 32'(m_sdata);
    if (a == OUT_BASE + 32'h08) return 32'(m_sen);
    if (a == OUT_BASE + 32'h10) return 32'(m_en);
`ifdef OTTER_IO_BOTH_EDGE_EN
    if (a == OUT_BASE + 32'h14) return 32'(m_edge);
`endif
    return 32'h0;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m_reset();
    else m_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("leds", 32'(leds), 32'(m_leds));
      check("segs", 32'(segs), 32'(m_segs));
      check("an", 32'(an), 32'(m_an));
      check("intr", 32'(intr), 32'(m_intr));
      check("iobus_in", IOBUS_in, m_read(IOBUS_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_addr = a; IOBUS_out = d; IOBUS_wr = 1'b1;
    tick();
    IOBUS_wr = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_addr = a;
    #1;
    check(nm, IOBUS_in, exp);
  endtask

  task automatic wait_an(input logic [3:0] v);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (an !== v && k < 40);
    check("an_reach", 32'(an), 32'(v));
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 2) return IN_BASE + 32'(4 * r);
    if (r <= 9) return OUT_BASE + 32'(4 * (r - 3));
    if (r == 10) return IN_BASE + 32'hC;
    return $urandom();
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    RST_N = 1'b0; IOBUS_addr = '0; IOBUS_out = '0; IOBUS_wr = 1'b0;
    switches = '0; buttons = '0;
    chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_segs", 32'(segs), 32'hFF);
    check("rst_an", 32'(an), 32'hF);
    RST_N = 1'b1;

    // LED write and readback
    bus_wr(OUT_BASE, 32'h0000ABCD);
    check("leds_abcd", 32'(leds), 32'h0000ABCD);
    rd_check("rd_leds", OUT_BASE, 32'h0000ABCD);
    rd_check("rd_unmapped", 32'h11008010, 32'h0);

    // Seven-segment scan with digits 0 and 2 enabled
    bus_wr(OUT_BASE + 32'h4, 32'h00001234);
    bus_wr(OUT_BASE + 32'h8, 32'h00000005);
    wait_an(4'b1110);
    check("seg_d0_4", 32'(segs), 32'h99);
    wait_an(4'b1111);
    check("seg_d1_off", 32'(segs), 32'hFF);
    wait_an(4'b1011);
    check("seg_d2_2", 32'(segs), 32'hA4);
    tick();

    // Button 2 bounces 1,0,1 then holds; debounced rises 10 edges later
    buttons[2] = 1'b1; tick();
    buttons[2] = 1'b0; tick();
    buttons[2] = 1'b1;
    repeat (9) tick();
    rd_check("db_before", IN_BASE + 32'h4, 32'h0);
    tick();
    rd_check("db_rise", IN_BASE + 32'h4, 32'h4);
    rd_check("pend_not_yet", IN_BASE + 32'h8, 32'h0);
    tick();
    rd_check("pend_set", IN_BASE + 32'h8, 32'h4);
    check("intr_masked", 32'(intr), 32'h0);
    bus_wr(OUT_BASE + 32'h10, 32'h4);
    check("intr_en_lag", 32'(intr), 32'h0);
    tick();
    check("intr_on", 32'(intr), 32'h1);

    // Release, then clear with no coincident edge
    buttons[2] = 1'b0;
    repeat (14) tick();
    bus_wr(OUT_BASE + 32'hC, 32'h4);
    rd_check("pend_clr", IN_BASE + 32'h8, 32'h0);
    check("intr_clr_lag", 32'(intr), 32'h1);
    tick();
    check("intr_clr", 32'(intr), 32'h0);

    // Clear coincident with a new rising edge: set wins
    buttons[2] = 1'b1;
    repeat (10) tick();
    bus_wr(OUT_BASE + 32'hC, 32'h4);
    rd_check("pend_set_wins", IN_BASE + 32'h8, 32'h4);
    tick();
    check("intr_after_race", 32'(intr), 32'h1);
    bus_wr(OUT_BASE + 32'hC, 32'h4);
    rd_check("pend_clr2", IN_BASE + 32'h8, 32'h0);
    tick();
    check("intr_clr2", 32'(intr), 32'h0);

    // Falling-edge interrupt on button 0
    bus_wr(OUT_BASE + 32'h14, 32'h1);
`ifdef OTTER_IO_BOTH_EDGE_EN
    rd_check("rd_irq_edge", OUT_BASE + 32'h14, 32'h1);
`else
    rd_check("rd_0x14_unmapped", OUT_BASE + 32'h14, 32'h0);
`endif
    buttons[0] = 1'b1;
    repeat (14) tick();
    bus_wr(OUT_BASE + 32'hC, 32'h1F);
    rd_check("pend_pre_release", IN_BASE + 32'h8, 32'h0);
    buttons[0] = 1'b0;
    repeat (14) tick();
`ifdef OTTER_IO_BOTH_EDGE_EN
    rd_check("pend_fall", IN_BASE + 32'h8, 32'h1);
`else
    rd_check("pend_no_fall", IN_BASE + 32'h8, 32'h0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int b = 0; b < BTN_W; b++)
        if ($urandom_range(0, 23) == 0) buttons[b] = ~buttons[b];
      if ($urandom_range(0, 7) == 0) switches = SW_W'($urandom());
      IOBUS_addr = pick_addr();
      IOBUS_out = $urandom();
      IOBUS_wr = ($urandom_range(0, 3) == 0);
    end
    IOBUS_wr = 1'b0;

    // Reset in the middle of a scan with all digits enabled
    bus_wr(OUT_BASE + 32'h0, 32'h0000FFFF);
    bus_wr(OUT_BASE + 32'h8, 32'hF);
    bus_wr(OUT_BASE + 32'h10, 32'h1F);
    repeat (5) tick();
    IOBUS_addr = OUT_BASE;
    #1;
    RST_N = 1'b0;
    #1;
    check("mrst_segs", 32'(segs), 32'hFF);
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_leds", 32'(leds), 32'h0);
    check("mrst_intr", 32'(intr), 32'h0);
    check("mrst_rd_leds", IOBUS_in, 32'h0);
    rd_check("mrst_rd_pend", IN_BASE + 32'h8, 32'h0);
    @(negedge CLK);
    #1;
    rd_check("mrst_rd_sen", OUT_BASE + 32'h8, 32'h0);
    rd_check("mrst_rd_en", OUT_BASE + 32'h10, 32'h0);
    tick();
    RST_N = 1'b1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
